rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port (wen_ARd/ARd/Rd_data) between NREQ writeback requesters
//  (ALU result, load data, base-writeback, multiply-long hi/lo) via round-robin valid/ready arbitration.

---
 rtl/rf_arb_pkg.sv | 15 +
 rtl/rf_write_arbiter_if.sv | 28 ++
 rtl/rr_priority_picker.sv | 28 ++
 rtl/rf_write_arbiter.sv | 96 +++++++++
 tb/tb_rf_write_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// Shared widths, register-file types and debug view for the register-file write arbiter.
package rf_arb_pkg;
  localparam int ADDR_W = 4;
  localparam int REG_W  = 32;
  localparam logic [ADDR_W-1:0] PC_IDX = 4'd15;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]  reg_data_t;

  // Internal arbiter state exposed for observation; sized for the largest NREQ (8).
  typedef struct packed {
    logic [2:0] ptr;
    logic [7:0] cnt;
  } rf_arb_dbg_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester handshake plus register-file write-port bundle for rf_write_arbiter.
interface rf_write_arbiter_if #(parameter int NREQ = 4);
  import rf_arb_pkg::*;

  // valid/ready: a transfer from requester i happens on a rising edge where
  // req_valid[i] & req_ready[i]; the requester keeps its payload stable until then.
  logic [NREQ-1:0]       req_valid;
  reg_addr_t [NREQ-1:0]  req_addr;
  reg_data_t [NREQ-1:0]  req_data;
  logic [NREQ-1:0]       req_ready;

  logic                  wen_ARd;
  reg_addr_t             ARd;
  reg_data_t             Rd_data;
  logic                  pc_write;
  logic [15:0]           busy_mask;
  logic                  flushing;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wen_ARd, ARd, Rd_data, pc_write, busy_mask, flushing
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wen_ARd, ARd, Rd_data, pc_write, busy_mask, flushing
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible bit at or after ptr_i, wrapping to 0.
module rr_priority_picker #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o
);
  always_comb begin : pick
    int   k;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = 0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr_i) + off;
      if (k >= N) k = k - N;
      if (!found && eligible_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = PW'(k);
      end
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with registered output
// stage and a post-R15 grant lockout window while the pipeline refills.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  rf_write_arbiter_if.slave   bus,
  output rf_arb_dbg_t         dbg_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wen_q, wen_d;
  reg_addr_t     ard_q, ard_d;
  reg_data_t     data_q, data_d;
  logic          pc_q, pc_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win_idx;
  logic            xfer;
  reg_addr_t       win_addr;
  reg_data_t       win_data;

  // Reset also masks grants so requests pending through reset are kept, not consumed.
  assign eligible = bus.req_valid & {NREQ{~stall & ~rst & (cnt_q == '0)}};

  rr_priority_picker #(.N(NREQ)) u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .idx_o      (win_idx)
  );

  assign bus.req_ready = grant;
  assign xfer          = |grant;
  assign win_addr      = bus.req_addr[win_idx];
  assign win_data      = bus.req_data[win_idx];

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wen_d  = wen_q;
    ard_d  = ard_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (!stall) begin
      wen_d = 1'b0;
      pc_d  = 1'b0;
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (xfer) begin
        wen_d  = 1'b1;
        ard_d  = win_addr;
        data_d = win_data;
        pc_d   = (win_addr == PC_IDX);
        ptr_d  = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        if (win_addr == PC_IDX) cnt_d = CW'(FLUSH_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      wen_q  <= 1'b0;
      ard_q  <= '0;
      data_q <= '0;
      pc_q   <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      wen_q  <= wen_d;
      ard_q  <= ard_d;
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  assign bus.wen_ARd   = wen_q;
  assign bus.ARd       = ard_q;
  assign bus.Rd_data   = data_q;
  assign bus.pc_write  = pc_q;
  assign bus.busy_mask = wen_q ? (16'b1 << ard_q) : 16'b0;
  assign bus.flushing  = (cnt_q != '0);

  assign dbg_o.ptr = 3'(ptr_q);
  assign dbg_o.cnt = 8'(cnt_q);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int FLUSH = 2;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.NREQ(NREQ)) bus ();
  rf_arb_dbg_t dbg;

  rf_write_arbiter #(.NREQ(NREQ), .FLUSH_CYCLES(FLUSH)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .bus   (bus.slave),
    .dbg_o (dbg)
  );

  int checks   = 0;
  int failures = 0;

  // Requester-side payload held by the bench
  logic [NREQ-1:0] v;
  logic [3:0]      a [NREQ];
  logic [31:0]     d [NREQ];

  // Reference model state
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic        m_wen = 1'b0;
  logic        m_pc  = 1'b0;
  logic [3:0]  m_ard = '0;
  logic [31:0] m_data = '0;
  logic [35:0] exp_q [$];

  function automatic int pick(input logic [NREQ-1:0] vv, input logic r, input logic s);
    if (r || s || m_cnt != 0) return -1;
    for (int off = 0; off < NREQ; off++)
      if (vv[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
    return -1;
  endfunction

  // One clock: drive inputs, check grant, advance model, check registered outputs.
  task automatic drive_cycle(input logic r, input logic s, output int w, output logic [NREQ-1:0] rdy);
    logic [NREQ-1:0] exp_rdy;
    logic [15:0]     exp_busy;
    logic [35:0]     got, want;
    rst   = r;
    stall = s;
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = a[i];
      bus.req_data[i] = d[i];
    end
    #1;
    w = pick(v, r, s);
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    rdy = bus.req_ready;
    checks++;
    if (bus.req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_rdy);
    end
    if (w >= 0) exp_q.push_back({a[w], d[w]});

    if (r) begin
      m_ptr = 0; m_cnt = 0; m_wen = 1'b0; m_pc = 1'b0; m_ard = '0; m_data = '0;
      exp_q.delete();
    end else if (!s) begin
      m_wen = 1'b0;
      m_pc  = 1'b0;
      if (m_cnt > 0) m_cnt--;
      if (w >= 0) begin
        m_wen  = 1'b1;
        m_ard  = a[w];
        m_data = d[w];
        m_pc   = (a[w] == 4'hF);
        m_ptr  = (w + 1) % NREQ;
        if (a[w] == 4'hF) m_cnt = FLUSH;
      end
    end
    exp_busy = '0;
    if (m_wen) exp_busy[m_ard] = 1'b1;

    @(posedge clk);
    #1;
    checks++;
    if (bus.wen_ARd !== m_wen || bus.ARd !== m_ard || bus.Rd_data !== m_data) begin
      failures++;
      $display("FAIL write_port: got wen=%b ARd=%h data=%h expected wen=%b ARd=%h data=%h",
               bus.wen_ARd, bus.ARd, bus.Rd_data, m_wen, m_ard, m_data);
    end
    checks++;
    if (bus.pc_write !== m_pc || bus.flushing !== (m_cnt != 0) || bus.busy_mask !== exp_busy) begin
      failures++;
      $display("FAIL side_outputs: got pc=%b flush=%b busy=%h expected pc=%b flush=%b busy=%h",
               bus.pc_write, bus.flushing, bus.busy_mask, m_pc, (m_cnt != 0), exp_busy);
    end
    if (!r && !s && bus.wen_ARd === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: got write %h:%h expected none", bus.ARd, bus.Rd_data);
      end else begin
        want = exp_q.pop_front();
        got  = {bus.ARd, bus.Rd_data};
        if (got !== want) begin
          failures++;
          $display("FAIL scoreboard: got %h expected %h", got, want);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int w; logic [NREQ-1:0] rdy;
    v = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin a[i] = 4'(i + 1); d[i] = 32'hA1 + 32'(i); end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, 1'b0, w, rdy);
      checks++;
      if (rdy !== 4'b0000 || bus.wen_ARd !== 1'b0 || bus.busy_mask !== 16'h0) begin
        failures++;
        $display("FAIL reset: got ready=%b wen=%b busy=%h expected 0 0 0", rdy, bus.wen_ARd, bus.busy_mask);
      end
    end
  endtask

  task automatic test_round_robin();
    int w; logic [NREQ-1:0] rdy;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 1'b0, w, rdy);
      checks++;
      if (rdy !== 4'(1 << k) || bus.ARd !== 4'(k + 1) || bus.Rd_data !== 32'hA1 + 32'(k)) begin
        failures++;
        $display("FAIL round_robin: got ready=%b ARd=%h data=%h expected ready=%b ARd=%h data=%h",
                 rdy, bus.ARd, bus.Rd_data, 4'(1 << k), 4'(k + 1), 32'hA1 + 32'(k));
      end
      v[k] = 1'b0;
    end
  endtask

  task automatic test_wrap();
    int w; logic [NREQ-1:0] rdy;
    v = 4'b0100; a[2] = 4'd6; d[2] = 32'h66;
    drive_cycle(1'b0, 1'b0, w, rdy);
    v = 4'b1001; a[0] = 4'd8; d[0] = 32'h80; a[3] = 4'd9; d[3] = 32'h90;
    drive_cycle(1'b0, 1'b0, w, rdy);
    checks++;
    if (rdy !== 4'b1000) begin failures++; $display("FAIL wrap_first: got %b expected 1000", rdy); end
    v[3] = 1'b0;
    drive_cycle(1'b0, 1'b0, w, rdy);
    checks++;
    if (rdy !== 4'b0001) begin failures++; $display("FAIL wrap_second: got %b expected 0001", rdy); end
    v[0] = 1'b0;
    checks++;
    if (dbg.ptr !== 3'd1) begin failures++; $display("FAIL wrap_ptr: got %0d expected 1", dbg.ptr); end
  endtask

  task automatic test_r15_lockout();
    int w; logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] exp_r [4];
    logic            exp_f [4];
    exp_r[0] = 4'b0001; exp_r[1] = 4'b0000; exp_r[2] = 4'b0000; exp_r[3] = 4'b0010;
    exp_f[0] = 1'b1;    exp_f[1] = 1'b1;    exp_f[2] = 1'b0;    exp_f[3] = 1'b0;
    v = 4'b1000; a[3] = 4'd2; d[3] = 32'h33;
    drive_cycle(1'b0, 1'b0, w, rdy);
    v = 4'b0011; a[0] = 4'hF; d[0] = 32'h20; a[1] = 4'd5; d[1] = 32'h55;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 1'b0, w, rdy);
      checks++;
      if (rdy !== exp_r[k] || bus.flushing !== exp_f[k]) begin
        failures++;
        $display("FAIL r15_lockout[%0d]: got ready=%b flushing=%b expected ready=%b flushing=%b",
                 k, rdy, bus.flushing, exp_r[k], exp_f[k]);
      end
      if (k == 0) begin
        checks++;
        if (bus.pc_write !== 1'b1 || bus.ARd !== 4'hF || bus.Rd_data !== 32'h20) begin
          failures++;
          $display("FAIL r15_write: got pc=%b ARd=%h data=%h expected 1 f 00000020",
                   bus.pc_write, bus.ARd, bus.Rd_data);
        end
        v[0] = 1'b0;
      end
    end
    v[1] = 1'b0;
  endtask

  task automatic test_stall();
    int w; logic [NREQ-1:0] rdy;
    v = 4'b0100; a[2] = 4'd7; d[2] = 32'hDEAD;
    drive_cycle(1'b0, 1'b0, w, rdy);
    v = 4'b0010; a[1] = 4'd3; d[1] = 32'h31;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 1'b1, w, rdy);
      checks++;
      if (rdy !== 4'b0 || bus.wen_ARd !== 1'b1 || bus.ARd !== 4'd7 ||
          bus.Rd_data !== 32'hDEAD || bus.busy_mask !== 16'h0080) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got ready=%b wen=%b ARd=%h data=%h busy=%h expected 0 1 7 dead 0080",
                 k, rdy, bus.wen_ARd, bus.ARd, bus.Rd_data, bus.busy_mask);
      end
    end
    drive_cycle(1'b0, 1'b0, w, rdy);
    checks++;
    if (rdy !== 4'b0010) begin failures++; $display("FAIL stall_resume: got %b expected 0010", rdy); end
    v[1] = 1'b0;
  endtask

  task automatic test_reset_mid_lockout();
    int w; logic [NREQ-1:0] rdy;
    v = 4'b0100; a[2] = 4'hF; d[2] = 32'hF0;
    drive_cycle(1'b0, 1'b0, w, rdy);
    v = 4'b1000; a[3] = 4'd9; d[3] = 32'h99;
    drive_cycle(1'b0, 1'b0, w, rdy);
    checks++;
    if (dbg.cnt !== 8'd1 || bus.flushing !== 1'b1) begin
      failures++;
      $display("FAIL mid_lockout: got cnt=%0d flushing=%b expected 1 1", dbg.cnt, bus.flushing);
    end
    drive_cycle(1'b1, 1'b0, w, rdy);
    checks++;
    if (bus.flushing !== 1'b0 || bus.wen_ARd !== 1'b0) begin
      failures++;
      $display("FAIL reset_lockout: got flushing=%b wen=%b expected 0 0", bus.flushing, bus.wen_ARd);
    end
    drive_cycle(1'b0, 1'b0, w, rdy);
    checks++;
    if (rdy !== 4'b1000 || bus.ARd !== 4'd9) begin
      failures++;
      $display("FAIL post_reset_grant: got ready=%b ARd=%h expected 1000 9", rdy, bus.ARd);
    end
    v[3] = 1'b0;
  endtask

  task automatic test_random();
    int w; logic [NREQ-1:0] rdy;
    logic r, s;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          a[i] = 4'($urandom_range(0, 15));
          d[i] = $urandom;
        end
      end
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 7) == 0);
      drive_cycle(r, s, w, rdy);
      if (w >= 0) v[w] = 1'b0;
    end
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    v     = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; end
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_wrap();
    test_r15_lockout();
    test_stall();
    test_reset_mid_lockout();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
